sdram_burst_arbiter: RTL and testbench
======================================

# sdram_burst_arbiter

Sits between the burst traffic sources (memory test generator, frame readers/writers) and the SDRAM core command port. Accepts one user burst read port and one user burst write port, arbitrates between them and splits each burst at SDRAM page boundaries. It issues one core command per sub-burst and returns a single finish pulse per user burst. Data strobes and data pass through with zero latency.

## Interface
- MEM_DATA_BITS, 32, data width
- ADDR_BITS, 23, word address width
- BURST_BITS, 10, burst length width (max length 2^BURST_BITS-1)
- COL_BITS, 9, column bits; page = 2^COL_BITS words

- mem_clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- rd_burst_req / wr_burst_req  in  1  user burst request, level
- rd_burst_len / wr_burst_len  in  BURST_BITS  words in burst
- rd_burst_addr / wr_burst_addr  in  ADDR_BITS  base word address
- rd_burst_data_valid  out  1  read word valid
- rd_burst_data  out  MEM_DATA_BITS  read word
- wr_burst_data_req  out  1  write word request, one cycle before data is consumed
- wr_burst_data  in  MEM_DATA_BITS  write word
- rd_burst_finish / wr_burst_finish  out  1  one-cycle pulse, user burst complete
- core_req  out  1  sub-burst command valid, held until core_ack
- core_we  out  1  1 = write, 0 = read
- core_addr  out  ADDR_BITS  sub-burst base address
- core_len  out  BURST_BITS  sub-burst length, never 0
- core_ack  in  1  one-cycle pulse, command accepted
- core_wr_data_req  in  1  core write word request
- core_wr_data  out  MEM_DATA_BITS  write word to core
- core_rd_data_valid / core_rd_data  in  1 / MEM_DATA_BITS  core read data
- core_done  in  1  one-cycle pulse, sub-burst finished; only after core_ack

## Operation
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE: sample requests. If both are pending, round-robin against last_grant; after reset a write wins the first tie. The granted op latches addr into cur, len into rem and sets op_we. If len = 0, go to FINISH directly with no core command. Otherwise go to ISSUE.
- Sub-burst length on ISSUE entry: sub = min(rem, 2^COL_BITS - cur[COL_BITS-1:0]), registered into core_len. core_addr = cur.
- ISSUE: core_req = 1 and core_we = op_we; core_addr and core_len are stable. On core_ack: cur <= cur + sub (mod 2^ADDR_BITS), rem <= rem - sub, then go to WAIT.
- WAIT: on core_done, go to FINISH if rem = 0, otherwise go to ISSUE.
- FINISH: pulse the finish output matching op_we for one cycle, update last_grant, return to IDLE.
- User requests are latched on grant. A source may drop its request after grant. A request still high during the finish cycle is not re-accepted until IDLE.
- Passthrough, combinational:
  - wr_burst_data_req = core_wr_data_req & op_we & busy
  - core_wr_data = wr_burst_data
  - rd_burst_data_valid = core_rd_data_valid & ~op_we & busy
  - rd_burst_data = core_rd_data
- Protocol violations: core_ack outside ISSUE and core_done outside WAIT are ignored.
- Reset, including mid-burst: state IDLE, the current burst is discarded with no finish pulse, last_grant = read. All outputs are 0: core_req, core_we, core_addr, core_len, both finish outputs, and the gated strobes.

## Timing
- User request high in IDLE at cycle N -> core_req high at N+1.
- core_ack at cycle M -> core_req low at M+1.
- core_done at cycle D:
  - next sub-burst core_req high at D+1, or
  - finish pulse at D+1, then IDLE at D+2.
- Zero-length burst: request at N -> finish at N+1.
- Back-to-back bursts: a new grant is possible in the cycle after the finish pulse.
- Passthrough adds 0 cycles.

## Configuration
- BURST_PAGE_SPLIT_EN defined: page splitting as described above.
- BURST_PAGE_SPLIT_EN undefined: sub = rem, so each user burst becomes exactly one core command. cur and rem are still updated and the state machine is unchanged.

## Test plan
- Write len 128, addr 0x000000 -> one core command (we=1, addr 0, len 128). 128 wr_burst_data_req strobes mirror core_wr_data_req. wr_burst_finish pulses at core_done+1.
- Read len 128, addr 0x0001C0, macro defined -> commands (0x1C0, 64) then (0x200, 64), with the second core_req at done+1. One rd_burst_finish. Macro undefined -> single command (0x1C0, 128).
- rd and wr requests both held high from reset -> grants in order write, read, write, read. Each finish pulses only for the matching op.
- Write len 0 at addr 0x100 -> core_req never asserts; wr_burst_finish pulses 1 cycle after the request.
- Read len 256, addr 0x7FFF80 -> commands (0x7FFF80, 128) then (0x000000, 128), address wraps.
- rst asserted 3 cycles after core_ack of a 128-word write -> all outputs 0 immediately, no finish pulse. The next request starts fresh at IDLE with write priority.

Source files
------------

// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter
//
// Arbitrates one user burst-read port and one user burst-write port onto the
// SDRAM core command port. Each user burst is cut into sub-bursts that never
// cross an SDRAM page, one core command is issued per sub-burst, and a single
// finish pulse is returned per user burst. Data strobes and data pass straight
// through with no added latency.
//
// Configuration macro: BURST_PAGE_SPLIT_EN
//   defined   - sub-bursts are clipped at 2^COL_BITS-word page boundaries
//   undefined - each user burst becomes exactly one core command
//
// Ports
//   mem_clk, rst                 clock (rising edge) / async active-high reset
//   rd_burst_req/len/addr        user read request (level), length, base address
//   rd_burst_data_valid/data     read words returned to the user
//   rd_burst_finish              one-cycle pulse, user read burst complete
//   wr_burst_req/len/addr        user write request (level), length, base address
//   wr_burst_data_req/data       write word request to user / write word from user
//   wr_burst_finish              one-cycle pulse, user write burst complete
//   core_req/we/addr/len         sub-burst command, held until core_ack
//   core_ack, core_done          command accepted / sub-burst finished pulses
//   core_wr_data_req/wr_data     core write word request / write word to core
//   core_rd_data_valid/rd_data   core read data
module sdram_burst_arbiter #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 23,
    parameter int BURST_BITS    = 10,
    parameter int COL_BITS      = 9
) (
    input  logic                     mem_clk,
    input  logic                     rst,
    input  logic                     rd_burst_req,
    input  logic [BURST_BITS-1:0]    rd_burst_len,
    input  logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish,
    input  logic                     wr_burst_req,
    input  logic [BURST_BITS-1:0]    wr_burst_len,
    input  logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic                     wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     wr_burst_finish,
    output logic                     core_req,
    output logic                     core_we,
    output logic [ADDR_BITS-1:0]     core_addr,
    output logic [BURST_BITS-1:0]    core_len,
    input  logic                     core_ack,
    input  logic                     core_wr_data_req,
    output logic [MEM_DATA_BITS-1:0] core_wr_data,
    input  logic                     core_rd_data_valid,
    input  logic [MEM_DATA_BITS-1:0] core_rd_data,
    input  logic                     core_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t                 state_q, state_d;
    logic                   op_we_q, op_we_d;
    logic                   last_grant_wr_q, last_grant_wr_d;
    logic [ADDR_BITS-1:0]   cur_q, cur_d;
    logic [BURST_BITS-1:0]  rem_q, rem_d;
    logic                   core_req_q, core_req_d;
    logic [ADDR_BITS-1:0]   core_addr_q, core_addr_d;
    logic [BURST_BITS-1:0]  core_len_q, core_len_d;
    logic                   rd_finish_q, rd_finish_d;
    logic                   wr_finish_q, wr_finish_d;

    logic                   grant_wr;
    logic [ADDR_BITS-1:0]   req_addr;
    logic [BURST_BITS-1:0]  req_len;
    logic                   enter_issue;
    logic [BURST_BITS-1:0]  sub_len;
`ifdef BURST_PAGE_SPLIT_EN
    logic [31:0]            page_room;
`endif
    logic                   busy;

    // Round-robin: on a tie the side that did not win last time is granted.
    // last_grant resets to read, so the first tie after reset goes to write.
    assign grant_wr = wr_burst_req & (~rd_burst_req | ~last_grant_wr_q);
    assign req_addr = grant_wr ? wr_burst_addr : rd_burst_addr;
    assign req_len  = grant_wr ? wr_burst_len  : rd_burst_len;
    assign busy     = (state_q != IDLE);

    always_comb begin
        // NOTE: every _d gets a hold/default value first so that no path
        // through the case statement leaves a variable unassigned (no latches).
        state_d         = state_q;
        op_we_d         = op_we_q;
        last_grant_wr_d = last_grant_wr_q;
        cur_d           = cur_q;
        rem_d           = rem_q;
        core_req_d      = core_req_q;
        core_addr_d     = core_addr_q;
        core_len_d      = core_len_q;
        rd_finish_d     = 1'b0;
        wr_finish_d     = 1'b0;
        enter_issue     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_burst_req || wr_burst_req) begin
                    op_we_d = grant_wr;
                    cur_d   = req_addr;
                    rem_d   = req_len;
                    if (req_len == '0) begin
                        // Empty burst: acknowledge straight away, no core command.
                        state_d     = FINISH;
                        wr_finish_d = grant_wr;
                        rd_finish_d = ~grant_wr;
                    end else begin
                        state_d     = ISSUE;
                        core_req_d  = 1'b1;
                        enter_issue = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (core_ack) begin
                    cur_d      = cur_q + ADDR_BITS'(core_len_q);
                    rem_d      = rem_q - core_len_q;
                    core_req_d = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (core_done) begin
                    if (rem_q == '0) begin
                        state_d     = FINISH;
                        wr_finish_d = op_we_q;
                        rd_finish_d = ~op_we_q;
                    end else begin
                        state_d     = ISSUE;
                        core_req_d  = 1'b1;
                        enter_issue = 1'b1;
                    end
                end
            end
            FINISH: begin
                last_grant_wr_d = op_we_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Sub-burst length is computed from the values the burst will hold
        // in ISSUE, so grant and continuation share the same path.
`ifdef BURST_PAGE_SPLIT_EN
        page_room = (32'd1 << COL_BITS) - 32'(cur_d[COL_BITS-1:0]);
        sub_len   = (32'(rem_d) > page_room) ? BURST_BITS'(page_room) : rem_d;
`else
        sub_len   = rem_d;
`endif
        if (enter_issue) begin
            core_addr_d = cur_d;
            core_len_d  = sub_len;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            op_we_q         <= 1'b0;
            last_grant_wr_q <= 1'b0;
            cur_q           <= '0;
            rem_q           <= '0;
            core_req_q      <= 1'b0;
            core_addr_q     <= '0;
            core_len_q      <= '0;
            rd_finish_q     <= 1'b0;
            wr_finish_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_we_q         <= op_we_d;
            last_grant_wr_q <= last_grant_wr_d;
            cur_q           <= cur_d;
            rem_q           <= rem_d;
            core_req_q      <= core_req_d;
            core_addr_q     <= core_addr_d;
            core_len_q      <= core_len_d;
            rd_finish_q     <= rd_finish_d;
            wr_finish_q     <= wr_finish_d;
        end
    end

    assign core_req        = core_req_q;
    assign core_we         = op_we_q;
    assign core_addr       = core_addr_q;
    assign core_len        = core_len_q;
    assign rd_burst_finish = rd_finish_q;
    assign wr_burst_finish = wr_finish_q;

    // Zero-latency passthrough; strobes are gated to the active direction.
    assign wr_burst_data_req   = core_wr_data_req & op_we_q & busy;
    assign core_wr_data        = wr_burst_data;
    assign rd_burst_data_valid = core_rd_data_valid & ~op_we_q & busy;
    assign rd_burst_data       = core_rd_data;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb_sdram_burst_arbiter
//
// Self-checking bench for sdram_burst_arbiter. Expected core commands and
// finish pulses are pushed to queues when user bursts are requested and are
// popped and compared as the core-side responder sees them. Honours the
// BURST_PAGE_SPLIT_EN macro in its reference model.
module tb_sdram_burst_arbiter;

    localparam int DW = 32;
    localparam int AW = 23;
    localparam int BW = 10;

    logic          mem_clk = 1'b0;
    logic          rst;
    logic          rd_burst_req, wr_burst_req;
    logic [BW-1:0] rd_burst_len, wr_burst_len;
    logic [AW-1:0] rd_burst_addr, wr_burst_addr;
    logic          rd_burst_data_valid, wr_burst_data_req;
    logic [DW-1:0] rd_burst_data, wr_burst_data;
    logic          rd_burst_finish, wr_burst_finish;
    logic          core_req, core_we, core_ack, core_done;
    logic [AW-1:0] core_addr;
    logic [BW-1:0] core_len;
    logic          core_wr_data_req, core_rd_data_valid;
    logic [DW-1:0] core_wr_data, core_rd_data;

    sdram_burst_arbiter dut (
        .mem_clk             (mem_clk),
        .rst                 (rst),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_finish     (rd_burst_finish),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_finish     (wr_burst_finish),
        .core_req            (core_req),
        .core_we             (core_we),
        .core_addr           (core_addr),
        .core_len            (core_len),
        .core_ack            (core_ack),
        .core_wr_data_req    (core_wr_data_req),
        .core_wr_data        (core_wr_data),
        .core_rd_data_valid  (core_rd_data_valid),
        .core_rd_data        (core_rd_data),
        .core_done           (core_done)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] len;
        logic          last;
    } cmd_t;

    cmd_t cmd_q[$];
    logic fin_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({core_req, core_we, core_addr, core_len, rd_burst_finish,
                    wr_burst_finish, wr_burst_data_req, rd_burst_data_valid});
    endfunction

    // Reference model: split a user burst into the expected core commands.
    task automatic expect_burst(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] len);
        logic [AW-1:0] a;
        int            rem;
        int            room;
        int            sub;
        cmd_t          c;
        a   = addr;
        rem = int'(len);
        while (rem > 0) begin
`ifdef BURST_PAGE_SPLIT_EN
            room = 512 - int'(a[8:0]);
`else
            room = rem;
`endif
            sub    = (rem < room) ? rem : room;
            rem    = rem - sub;
            c.we   = we;
            c.addr = a;
            c.len  = BW'(sub);
            c.last = (rem == 0);
            cmd_q.push_back(c);
            a = a + AW'(sub);
        end
        fin_q.push_back(we);
    endtask

    // Raise one user request for a cycle and check core_req follows at N+1.
    task automatic start_req(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] len);
        expect_burst(we, addr, len);
        if (we) begin
            wr_burst_req = 1'b1; wr_burst_addr = addr; wr_burst_len = len;
        end else begin
            rd_burst_req = 1'b1; rd_burst_addr = addr; rd_burst_len = len;
        end
        @(negedge mem_clk);
        check("grant_latency", 64'(core_req), 64'(1));
        rd_burst_req  = 1'b0;
        wr_burst_req  = 1'b0;
        // Scramble the user fields: the arbiter must have latched them.
        rd_burst_addr = ~addr; wr_burst_addr = ~addr;
        rd_burst_len  = ~len;  wr_burst_len  = ~len;
    endtask

    // Core responder: serves every sub-burst of one user burst.
    task automatic serve(input bit drop_reqs);
        cmd_t e;
        logic fw;
        int   waited;
        int   good;
        int   leak;
        bit   done_all;
        done_all = 1'b0;
        while (!done_all) begin
            waited = 0;
            while (!core_req && waited < 50) begin
                @(negedge mem_clk);
                waited++;
            end
            if (!core_req) begin
                check("core_req_timeout", 64'(core_req), 64'(1));
                return;
            end
            if (cmd_q.size() == 0) begin
                check("unexpected_core_req", 64'(core_req), 64'(0));
                return;
            end
            e = cmd_q.pop_front();
            check("core_we",   64'(core_we),   64'(e.we));
            check("core_addr", 64'(core_addr), 64'(e.addr));
            check("core_len",  64'(core_len),  64'(e.len));

            core_ack = 1'b1;
            @(negedge mem_clk);
            core_ack = 1'b0;
            check("core_req_drop", 64'(core_req), 64'(0));

            good = 0;
            leak = 0;
            for (int i = 0; i < int'(e.len); i++) begin
                // The opposite direction's core strobe is also raised; the
                // user-side strobe for it must stay gated off.
                core_wr_data_req   = 1'b1;
                core_rd_data_valid = 1'b1;
                wr_burst_data      = 32'hC0DE_0000 ^ 32'(i);
                core_rd_data       = 32'hA500_0000 ^ 32'(i);
                #1;
                if (e.we) begin
                    if (wr_burst_data_req && core_wr_data == (32'hC0DE_0000 ^ 32'(i))) good++;
                    if (rd_burst_data_valid) leak++;
                end else begin
                    if (rd_burst_data_valid && rd_burst_data == (32'hA500_0000 ^ 32'(i))) good++;
                    if (wr_burst_data_req) leak++;
                end
                @(negedge mem_clk);
            end
            core_wr_data_req   = 1'b0;
            core_rd_data_valid = 1'b0;
            check("strobe_mirror", 64'(good), 64'(e.len));
            check("strobe_leak",   64'(leak), 64'(0));

            core_done = 1'b1;
            @(negedge mem_clk);
            core_done = 1'b0;
            if (e.last) begin
                fw = fin_q.pop_front();
                check("finish_pulse", 64'({rd_burst_finish, wr_burst_finish}), 64'({~fw, fw}));
                check("no_req_after_last", 64'(core_req), 64'(0));
                if (drop_reqs) begin
                    rd_burst_req = 1'b0;
                    wr_burst_req = 1'b0;
                end
                @(negedge mem_clk);
                check("finish_one_cycle", 64'({rd_burst_finish, wr_burst_finish}), 64'(0));
                done_all = 1'b1;
            end else begin
                check("next_sub_req", 64'(core_req), 64'(1));
                check("no_early_finish", 64'({rd_burst_finish, wr_burst_finish}), 64'(0));
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rd_burst_req = 1'b0; wr_burst_req = 1'b0;
        rd_burst_len = '0;   wr_burst_len = '0;
        rd_burst_addr = '0;  wr_burst_addr = '0;
        wr_burst_data = '0;  core_rd_data = '0;
        core_ack = 1'b0;     core_done = 1'b0;
        core_wr_data_req = 1'b1;
        core_rd_data_valid = 1'b1;

        // Reset and idle: everything low, strobes gated while not busy.
        repeat (2) @(negedge mem_clk);
        check("reset_outs", all_outs(), 64'(0));
        rst = 1'b0;
        @(negedge mem_clk);
        check("idle_outs", all_outs(), 64'(0));
        core_wr_data_req   = 1'b0;
        core_rd_data_valid = 1'b0;

        // Stray ack/done in IDLE are ignored.
        core_ack = 1'b1; core_done = 1'b1;
        @(negedge mem_clk);
        core_ack = 1'b0; core_done = 1'b0;
        @(negedge mem_clk);
        check("stray_ack_done", all_outs(), 64'(0));

        // Single page-aligned write.
        start_req(1'b1, 23'h000000, 10'd128);
        serve(1'b0);

        // Read crossing a page boundary.
        start_req(1'b0, 23'h0001C0, 10'd128);
        serve(1'b0);

        // Read wrapping the top of the address space.
        start_req(1'b0, 23'h7FFF80, 10'd256);
        serve(1'b0);

        // Zero-length write: finish at N+1, no core command.
        fin_q.push_back(1'b1);
        wr_burst_req = 1'b1; wr_burst_addr = 23'h000100; wr_burst_len = 10'd0;
        @(negedge mem_clk);
        check("zero_len_finish", 64'({rd_burst_finish, wr_burst_finish}), 64'({~fin_q[0], fin_q[0]}));
        void'(fin_q.pop_front());
        check("zero_len_no_req", 64'(core_req), 64'(0));
        wr_burst_req = 1'b0;
        @(negedge mem_clk);
        check("zero_len_done", 64'({core_req, rd_burst_finish, wr_burst_finish}), 64'(0));

        // Reset in the middle of a write burst.
        wr_burst_req = 1'b1; wr_burst_addr = 23'h000040; wr_burst_len = 10'd128;
        @(negedge mem_clk);
        wr_burst_req = 1'b0;
        check("mid_cmd", 64'({core_req, core_we, core_addr, core_len}),
              64'({1'b1, 1'b1, 23'h000040, 10'd128}));
        core_ack = 1'b1;
        @(negedge mem_clk);
        core_ack = 1'b0;
        core_wr_data_req = 1'b1;
        repeat (2) @(negedge mem_clk);
        check("mid_strobe_live", 64'(wr_burst_data_req), 64'(1));
        #2 rst = 1'b1;
        #1 check("mid_reset_outs", all_outs(), 64'(0));
        // Both users request during reset; write must win the first grant.
        rd_burst_req = 1'b1; rd_burst_addr = 23'h000020; rd_burst_len = 10'd3;
        wr_burst_req = 1'b1; wr_burst_addr = 23'h000010; wr_burst_len = 10'd4;
        @(negedge mem_clk);
        check("reset_hold_outs", all_outs(), 64'(0));
        core_wr_data_req = 1'b0;
        rst = 1'b0;
        expect_burst(1'b1, 23'h000010, 10'd4);
        expect_burst(1'b0, 23'h000020, 10'd3);
        expect_burst(1'b1, 23'h000010, 10'd4);
        expect_burst(1'b0, 23'h000020, 10'd3);
        @(negedge mem_clk);
        check("post_reset_grant", 64'({core_req, core_we}), 64'({1'b1, 1'b1}));
        serve(1'b0);
        serve(1'b0);
        serve(1'b0);
        serve(1'b1);
        repeat (3) @(negedge mem_clk);
        check("quiet_after_ties", 64'({core_req, rd_burst_finish, wr_burst_finish}), 64'(0));
        check("queues_drained", 64'(cmd_q.size() + fin_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
